// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider_sgn iterative divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Widest operand the magnitude helper handles.
  localparam int MAX_W = 64;

  // Number of RUN cycles for a WIDTH-bit divide retiring k bits per cycle.
  function automatic int div_steps(input int width, input int k);
    return width / k;
  endfunction

  // Two's-complement magnitude of the low 'width' bits of v (zero-extended).
  // The most negative value maps to 2^(width-1), which is the correct
  // unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input int width);
    logic [MAX_W-1:0] mask;
    logic             neg;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    neg  = |((v >> (width - 1)) & MAX_W'(1));
    return neg ? ((~v + MAX_W'(1)) & mask) : (v & mask);
  endfunction

endpackage

// File: rtl/divider_sgn_if.sv
// Request/result bundle between a datapath controller and divider_sgn.
interface divider_sgn_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             val;
  logic             dbz;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (output start, sgn, x, y, input busy, val, dbz, q, r);
  modport slave  (input start, sgn, x, y, output busy, val, dbz, q, r);
endinterface

// File: rtl/div_step.sv
// Combinational K-step restoring division slice. Each step shifts one
// dividend bit (MSB first) into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module div_step #(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [K-1:0]     bits_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [K-1:0]     qbits_o
);

  logic [WIDTH:0] p;

  // Chain of K shift/compare/subtract steps; the remainder stays below the
  // divisor between steps, so WIDTH+1 bits never overflow.
  always_comb begin
    p       = rem_i;
    qbits_o = '0;
    for (int i = K - 1; i >= 0; i--) begin
      p = {p[WIDTH-1:0], bits_i[i]};
      if (p >= {1'b0, div_i}) begin
        p          = p - {1'b0, div_i};
        qbits_o[i] = 1'b1;
      end
    end
    rem_o = p;
  end

endmodule

// File: rtl/divider_sgn.sv
// Iterative signed/unsigned integer divider, K quotient bits per cycle.
// Optional feature: define DIVIDER_SGN_FAST_PATH_EN to skip the RUN phase
// when |x| < |y| or |y| == 1 (results unchanged, only latency shrinks).
module divider_sgn
  import divider_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic          clk,
  input  logic          rst,
  divider_sgn_if.slave  bus
);

  localparam int N  = div_steps(WIDTH, K);
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || K < 1 || WIDTH > MAX_W || (WIDTH % K) != 0) begin : g_bad_cfg
    $error("divider_sgn: WIDTH must be >= 2 and <= MAX_W, and K must divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits in, quotient bits out
  logic [WIDTH-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             val_q, val_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_x, mag_y;
  logic             fast_hit;
  logic [WIDTH:0]   step_rem;
  logic [K-1:0]     step_qbits;

  assign mag_x = bus.sgn ? WIDTH'(abs_w(MAX_W'(bus.x), WIDTH)) : bus.x;
  assign mag_y = bus.sgn ? WIDTH'(abs_w(MAX_W'(bus.y), WIDTH)) : bus.y;

`ifdef DIVIDER_SGN_FAST_PATH_EN
  assign fast_hit = (mag_x < mag_y) || (mag_y == WIDTH'(1));
`else
  assign fast_hit = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH), .K(K)) u_step (
    .rem_i   (rem_q),
    .bits_i  (dvd_q[WIDTH-1 -: K]),
    .div_i   (dsr_q),
    .rem_o   (step_rem),
    .qbits_o (step_qbits)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: zero divisor never leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && bus.y != '0) state_d = fast_hit ? FIX : RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch, iteration, sign fix-up.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    negq_d = negq_q;
    negr_d = negr_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    val_d  = val_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d = 1'b0;
          if (bus.y == '0) begin
            dbz_d = 1'b1;
          end else begin
            dbz_d  = 1'b0;
            dsr_d  = mag_y;
            negq_d = bus.sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
            negr_d = bus.sgn & bus.x[WIDTH-1];
            cnt_d  = CW'(N);
            rem_d  = '0;
            dvd_d  = mag_x;
            // Precomputed magnitudes for the short-cut cases.
            if (fast_hit && (mag_x < mag_y)) begin
              dvd_d = '0;
              rem_d = {1'b0, mag_x};
            end
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = (dvd_q << K) | WIDTH'(step_qbits);
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        quo_d = negq_q ? -dvd_q : dvd_q;
        rmd_d = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        val_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      val_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      val_q  <= val_d;
      dbz_q  <= dbz_d;
    end
  end

  // Outputs: busy covers RUN and FIX.
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.val  = val_q;
    bus.dbz  = dbz_q;
    bus.q    = quo_q;
    bus.r    = rmd_q;
  end

endmodule

// File: tb/tb_divider_sgn.sv
// Self-checking bench for divider_sgn: a K=1 and a K=2 instance share the
// same stimulus; results are checked against table constants and a model.
module tb_divider_sgn;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_sgn_if #(.WIDTH(W)) b1 ();
  divider_sgn_if #(.WIDTH(W)) b2 ();

  divider_sgn #(.WIDTH(W), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  divider_sgn #(.WIDTH(W), .K(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    bit         s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    int         lat1;
    int         lat2;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_q   = 8'd0;
  logic [7:0] last_r   = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic s, input logic [7:0] x, input logic [7:0] y);
    b1.start = st; b1.sgn = s; b1.x = x; b1.y = y;
    b2.start = st; b2.sgn = s; b2.x = x; b2.y = y;
  endtask

  // Reference division: truncate toward zero, remainder follows dividend.
  task automatic ref_div(input bit s, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] q, output logic [7:0] r);
    int xs, ys;
    if (s) begin
      xs = int'($signed(x));
      ys = int'($signed(y));
    end else begin
      xs = int'(x);
      ys = int'(y);
    end
    q = 8'(xs / ys);
    r = 8'(xs % ys);
  endtask

  function automatic bit is_fast(input bit s, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] mx, my;
    mx = (s && x[7]) ? (8'd0 - x) : x;
    my = (s && y[7]) ? (8'd0 - y) : y;
    return (mx < my) || (my == 8'd1);
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy1"}, b1.busy, 0); chk({tag, "_val1"}, b1.val, 0);
    chk({tag, "_dbz1"}, b1.dbz, 0);   chk({tag, "_q1"}, b1.q, 0);
    chk({tag, "_r1"}, b1.r, 0);
    chk({tag, "_busy2"}, b2.busy, 0); chk({tag, "_val2"}, b2.val, 0);
    chk({tag, "_dbz2"}, b2.dbz, 0);   chk({tag, "_q2"}, b2.q, 0);
    chk({tag, "_r2"}, b2.r, 0);
  endtask

  // One division; 'hold' keeps start asserted (x=100, y=7) for that many
  // edges after acceptance to show busy-time requests are ignored.
  task automatic run_op(input bit s, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eq, input logic [7:0] er, input int hold);
    exp_t e;
    int   lat1, lat2;
    bit   fast;
    fast = 1'b0;
`ifdef DIVIDER_SGN_FAST_PATH_EN
    fast = is_fast(s, x, y);
`endif
    e.q    = eq;
    e.r    = er;
    e.lat1 = fast ? 1 : 9;
    e.lat2 = fast ? 1 : 5;
    sb.push_back(e);

    @(negedge clk);
    drive(1'b1, s, x, y);
    @(posedge clk); #1;
    if (hold > 0) drive(1'b1, 1'b0, 8'd100, 8'd7);
    else          drive(1'b0, 1'b0, 8'd0, 8'd0);
    chk("accept_busy1", b1.busy, 1); chk("accept_busy2", b2.busy, 1);
    chk("accept_dbz1", b1.dbz, 0);   chk("accept_val1", b1.val, 0);

    lat1 = -1;
    lat2 = -1;
    for (int i = 1; i <= 20 && (lat1 < 0 || lat2 < 0); i++) begin
      @(posedge clk); #1;
      if (i >= hold) drive(1'b0, 1'b0, 8'd0, 8'd0);
      if (lat1 < 0 && b1.val === 1'b1) lat1 = i;
      if (lat2 < 0 && b2.val === 1'b1) lat2 = i;
    end

    e = sb.pop_front();
    chk("lat_k1", lat1, e.lat1); chk("lat_k2", lat2, e.lat2);
    chk("q_k1", b1.q, e.q);      chk("r_k1", b1.r, e.r);
    chk("q_k2", b2.q, e.q);      chk("r_k2", b2.r, e.r);
    chk("done_busy1", b1.busy, 0);
    last_q = e.q;
    last_r = e.r;
    $display("op sgn=%0d x=%0d y=%0d -> q=%0d r=%0d lat(K1)=%0d lat(K2)=%0d (expect q=%0d r=%0d)",
             s, x, y, b1.q, b1.r, lat1, lat2, e.q, e.r);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 8'd11,  8'd3,   8'd3,   8'd2};
    vecs[1]  = '{1'b1, 8'd248, 8'd254, 8'd4,   8'd0};
    vecs[2]  = '{1'b1, 8'd249, 8'd2,   8'd253, 8'd255};
    vecs[3]  = '{1'b0, 8'd248, 8'd254, 8'd0,   8'd248};
    vecs[4]  = '{1'b1, 8'd128, 8'd255, 8'd128, 8'd0};
    vecs[5]  = '{1'b0, 8'd128, 8'd255, 8'd0,   8'd128};
    vecs[6]  = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5};
    vecs[7]  = '{1'b1, 8'd156, 8'd1,   8'd156, 8'd0};
    vecs[8]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0};
    vecs[9]  = '{1'b1, 8'd127, 8'd254, 8'd193, 8'd1};
    vecs[10] = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4};
    vecs[11] = '{1'b1, 8'd201, 8'd7,   8'd249, 8'd250};

    drive(1'b0, 1'b0, 8'd0, 8'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors, back to back.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, 0);

    // Divide by zero: flag only, results held, then cleared by a good start.
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd10, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    chk("dbz_flag1", b1.dbz, 1);  chk("dbz_flag2", b2.dbz, 1);
    chk("dbz_val1", b1.val, 0);   chk("dbz_busy1", b1.busy, 0);
    chk("dbz_busy2", b2.busy, 0);
    chk("dbz_qhold1", b1.q, last_q); chk("dbz_rhold1", b1.r, last_r);
    $display("op sgn=0 x=10 y=0 -> dbz=%0d val=%0d busy=%0d", b1.dbz, b1.val, b1.busy);
    run_op(1'b0, 8'd11, 8'd3, 8'd3, 8'd2, 0);

    // Start while busy is ignored.
    run_op(1'b0, 8'd11, 8'd3, 8'd3, 8'd2, 3);

    // Reset in the middle of RUN aborts with no result.
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd11, 8'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_noval1", b1.val, 0); chk("midrst_noval2", b2.val, 0);
    $display("op reset mid-run -> busy=%0d val=%0d q=%0d r=%0d", b1.busy, b1.val, b1.q, b1.r);

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] rx, ry, eq, er;
      bit rs;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(1, 255));
      rs = 1'($urandom_range(0, 1));
      ref_div(rs, rx, ry, eq, er);
      run_op(rs, rx, ry, eq, er, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
